// File: rtl/vx_csr_sched_tracker_pkg.sv
// rtl/vx_csr_sched_tracker_pkg.sv - shared widths and types for the scheduler-side CSR tracker
package vx_csr_sched_tracker_pkg;

   localparam int NUM_WARPS_DEF   = 4;
   localparam int NUM_THREADS_DEF = 4;
   localparam int PEND_W_DEF      = 4;
   localparam int CYCLES_W        = 64;

   function automatic int wid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [NUM_WARPS_DEF-1:0][NUM_THREADS_DEF-1:0] tmask_arr_t;
   typedef logic [CYCLES_W-1:0]                           cycles_t;

endpackage

// File: rtl/vx_pend_counter.sv
// rtl/vx_pend_counter.sv - per-warp in-flight instruction counter with full/le1/underflow flags
module vx_pend_counter
   import vx_csr_sched_tracker_pkg::*;
#(
   parameter int PEND_W = PEND_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic le1,
   output logic underflow
);

   logic [PEND_W-1:0] count_q, count_d;

   always_comb begin
      count_d   = count_q;
      underflow = 1'b0;
      if (inc && !dec && !full) begin
         count_d = count_q + PEND_W'(1);
      end else if (dec && !inc) begin
         if (count_q == '0) underflow = 1'b1;
         else               count_d   = count_q - PEND_W'(1);
      end
   end

   assign full = &count_q;
   assign le1  = (count_q <= PEND_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/vx_csr_sched_tracker.sv
// rtl/vx_csr_sched_tracker.sv - warp CSR lock, pending counts and status snapshots for the CSR unit
// Optional stall counter output enabled by VX_CSR_TRACK_PERF_EN.
module vx_csr_sched_tracker
   import vx_csr_sched_tracker_pkg::*;
#(
   parameter  int NUM_WARPS   = NUM_WARPS_DEF,
   parameter  int NUM_THREADS = NUM_THREADS_DEF,
   parameter  int PEND_W      = PEND_W_DEF,
   localparam int WID_W       = wid_width(NUM_WARPS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             issue_valid,
   input  logic [WID_W-1:0]                 issue_wid,
   input  logic                             issue_is_csr,
   output logic                             issue_ready,
   input  logic                             commit_valid,
   input  logic [WID_W-1:0]                 commit_wid,
   input  logic [WID_W-1:0]                 alm_empty_wid,
   output logic                             alm_empty,
   input  logic                             unlock_warp,
   input  logic [WID_W-1:0]                 unlock_wid,
   input  logic [NUM_WARPS-1:0]             active_warps_in,
   input  logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks_in,
   output logic [CYCLES_W-1:0]              cycles,
   output logic [NUM_WARPS-1:0]             active_warps,
   output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
   output logic [NUM_WARPS-1:0]             warp_locked,
`ifdef VX_CSR_TRACK_PERF_EN
   output logic [31:0]                      csr_stall_cycles,
`endif
   output logic                             err
);

   logic [NUM_WARPS-1:0] inc, dec, full, le1, underflow;
   logic                 issue_fire;

   logic [NUM_WARPS-1:0]             warp_locked_q, warp_locked_d;
   logic                             err_q, err_d;
   logic [CYCLES_W-1:0]              cycles_q, cycles_d;
   logic [NUM_WARPS-1:0]             active_warps_q, active_warps_d;
   logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks_q, thread_masks_d;
`ifdef VX_CSR_TRACK_PERF_EN
   logic [31:0]                      stall_q, stall_d;
`endif

   assign issue_ready = !warp_locked_q[issue_wid] && !full[issue_wid];
   assign issue_fire  = issue_valid && issue_ready;
   assign alm_empty   = le1[alm_empty_wid];

   for (genvar g = 0; g < NUM_WARPS; g++) begin : g_pend
      assign inc[g] = issue_fire   && (issue_wid  == WID_W'(g));
      assign dec[g] = commit_valid && (commit_wid == WID_W'(g));
      vx_pend_counter #(.PEND_W(PEND_W)) u_pend_counter (
         .clk       (clk),
         .reset     (reset),
         .inc       (inc[g]),
         .dec       (dec[g]),
         .full      (full[g]),
         .le1       (le1[g]),
         .underflow (underflow[g])
      );
   end

   always_comb begin
      warp_locked_d  = warp_locked_q;
      err_d          = err_q | (|underflow);
      cycles_d       = cycles_q + CYCLES_W'(1);
      active_warps_d = active_warps_in;
      thread_masks_d = thread_masks_in;
      // A locked warp blocks issue, so unlock and a CSR lock never collide on one warp.
      if (unlock_warp) begin
         if (warp_locked_q[unlock_wid]) warp_locked_d[unlock_wid] = 1'b0;
         else                           err_d                     = 1'b1;
      end
      if (issue_fire && issue_is_csr) warp_locked_d[issue_wid] = 1'b1;
`ifdef VX_CSR_TRACK_PERF_EN
      stall_d = stall_q;
      if (issue_valid && warp_locked_q[issue_wid] && (stall_q != '1))
         stall_d = stall_q + 32'd1;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warp_locked_q  <= '0;
         err_q          <= 1'b0;
         cycles_q       <= '0;
         active_warps_q <= '0;
         thread_masks_q <= '0;
`ifdef VX_CSR_TRACK_PERF_EN
         stall_q        <= '0;
`endif
      end else begin
         warp_locked_q  <= warp_locked_d;
         err_q          <= err_d;
         cycles_q       <= cycles_d;
         active_warps_q <= active_warps_d;
         thread_masks_q <= thread_masks_d;
`ifdef VX_CSR_TRACK_PERF_EN
         stall_q        <= stall_d;
`endif
      end
   end

   assign warp_locked  = warp_locked_q;
   assign err          = err_q;
   assign cycles       = cycles_q;
   assign active_warps = active_warps_q;
   assign thread_masks = thread_masks_q;
`ifdef VX_CSR_TRACK_PERF_EN
   assign csr_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vx_csr_sched_tracker.sv
// tb/tb_vx_csr_sched_tracker.sv - directed and random checks of vx_csr_sched_tracker against a queue-free count model
module tb_vx_csr_sched_tracker;
   import vx_csr_sched_tracker_pkg::*;

   localparam int NW   = 4;
   localparam int PMAX = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_is_csr, issue_ready;
   logic [1:0]  issue_wid, commit_wid, alm_empty_wid, unlock_wid;
   logic        commit_valid, alm_empty, unlock_warp, err;
   logic [3:0]  active_warps_in, active_warps, warp_locked;
   tmask_arr_t  thread_masks_in, thread_masks;
   logic [63:0] cycles;
`ifdef VX_CSR_TRACK_PERF_EN
   logic [31:0] csr_stall_cycles;
`endif

   vx_csr_sched_tracker dut (
      .clk             (clk),
      .reset           (reset),
      .issue_valid     (issue_valid),
      .issue_wid       (issue_wid),
      .issue_is_csr    (issue_is_csr),
      .issue_ready     (issue_ready),
      .commit_valid    (commit_valid),
      .commit_wid      (commit_wid),
      .alm_empty_wid   (alm_empty_wid),
      .alm_empty       (alm_empty),
      .unlock_warp     (unlock_warp),
      .unlock_wid      (unlock_wid),
      .active_warps_in (active_warps_in),
      .thread_masks_in (thread_masks_in),
      .cycles          (cycles),
      .active_warps    (active_warps),
      .thread_masks    (thread_masks),
      .warp_locked     (warp_locked),
`ifdef VX_CSR_TRACK_PERF_EN
      .csr_stall_cycles(csr_stall_cycles),
`endif
      .err             (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   int          m_pend [NW];
   bit          m_lock [NW];
   bit          m_err;
   longint      m_cyc;
   logic [3:0]  m_aw;
   logic [15:0] m_tm;
   longint      m_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_ready(input int w);
      return !m_lock[w] && (m_pend[w] < PMAX);
   endfunction

   function automatic logic [3:0] m_lock_vec();
      logic [3:0] v;
      for (int i = 0; i < NW; i++) v[i] = m_lock[i];
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NW; i++) begin
         m_pend[i] = 0;
         m_lock[i] = 0;
      end
      m_err = 0; m_cyc = 0; m_aw = '0; m_tm = '0; m_stall = 0;
   endtask

   task automatic check_all();
      chk("issue_ready",  {63'd0, issue_ready}, {63'd0, m_ready(int'(issue_wid))});
      chk("alm_empty",    {63'd0, alm_empty},   {63'd0, m_pend[alm_empty_wid] <= 1});
      chk("warp_locked",  {60'd0, warp_locked}, {60'd0, m_lock_vec()});
      chk("err",          {63'd0, err},         {63'd0, m_err});
      chk("cycles",       cycles,               m_cyc);
      chk("active_warps", {60'd0, active_warps}, {60'd0, m_aw});
      chk("thread_masks", {48'd0, thread_masks}, {48'd0, m_tm});
`ifdef VX_CSR_TRACK_PERF_EN
      chk("csr_stall",    {32'd0, csr_stall_cycles}, m_stall);
`endif
   endtask

   // One clock: drive inputs, check at negedge, advance the model across the posedge.
   task automatic cyc(input bit iv, input int iw, input bit csr, input bit cv, input int cw,
                      input int aq, input bit uv, input int uw);
      int  np [NW];
      bit  nl [NW];
      bit  ne, fire;
      issue_valid = iv; issue_wid = 2'(iw); issue_is_csr = csr;
      commit_valid = cv; commit_wid = 2'(cw); alm_empty_wid = 2'(aq);
      unlock_warp = uv; unlock_wid = 2'(uw);
      active_warps_in = 4'($urandom); thread_masks_in = 16'($urandom);
      @(negedge clk);
      check_all();
      fire = iv && m_ready(iw);
      np = m_pend; nl = m_lock; ne = m_err;
      if (fire) np[iw] = np[iw] + 1;
      if (cv) begin
         if (m_pend[cw] + ((fire && iw == cw) ? 1 : 0) == 0) ne = 1;
         else np[cw] = np[cw] - 1;
      end
      if (uv) begin
         if (m_lock[uw]) nl[uw] = 0;
         else            ne = 1;
      end
      if (fire && csr) nl[iw] = 1;
      if (iv && m_lock[iw] && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
      @(posedge clk);
      #1;
      m_pend = np; m_lock = nl; m_err = ne; m_cyc++;
      m_aw = active_warps_in; m_tm = thread_masks_in;
   endtask

   task automatic idle(input int aq);
      cyc(0, 0, 0, 0, 0, aq, 0, 0);
   endtask

   initial begin
      logic [3:0] saved_lock;
      reset = 1'b0;
      issue_valid = 0; issue_wid = 0; issue_is_csr = 0; commit_valid = 0; commit_wid = 0;
      alm_empty_wid = 0; unlock_warp = 0; unlock_wid = 0; active_warps_in = 0; thread_masks_in = 0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cycles", cycles, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      reset = 1'b1;

      for (int w = 0; w < NW; w++) idle(w);
      chk("cycles_after4", cycles, 64'd4);

      // CSR lock on warp 1
      cyc(1, 1, 0, 0, 0, 1, 0, 0);
      cyc(1, 1, 1, 0, 0, 1, 0, 0);
      #1;
      chk("lock_w1", {60'd0, warp_locked}, 64'b0010);
      chk("alm_w1_pend2", {63'd0, alm_empty}, 64'd0);
      cyc(0, 0, 0, 1, 1, 1, 0, 0);
      #1;
      chk("alm_w1_pend1", {63'd0, alm_empty}, 64'd1);
      issue_wid = 2'd1;
      #1;
      chk("ready_w1_locked", {63'd0, issue_ready}, 64'd0);
      cyc(1, 1, 0, 0, 0, 1, 1, 1);
      #1;
      chk("unlocked_w1", {60'd0, warp_locked}, 64'd0);
      chk("ready_w1_unlocked", {63'd0, issue_ready}, 64'd1);
      cyc(0, 0, 0, 1, 1, 1, 0, 0);

      // simultaneous issue/commit
      cyc(1, 2, 0, 0, 0, 2, 0, 0);
      cyc(1, 2, 0, 1, 2, 2, 0, 0);
      cyc(1, 3, 0, 0, 0, 3, 0, 0);
      cyc(1, 0, 0, 1, 3, 3, 0, 0);
      chk("pend3_zero_model", m_pend[3], 0);

      // saturation on warp 0
      while (m_pend[0] < PMAX) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      issue_wid = 2'd0; #1;
      chk("ready_w0_full", {63'd0, issue_ready}, 64'd0);
      issue_wid = 2'd1; #1;
      chk("ready_w1_notfull", {63'd0, issue_ready}, 64'd1);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      issue_wid = 2'd0; #1;
      chk("ready_w0_after_commit", {63'd0, issue_ready}, 64'd1);

      // underflow and spurious unlock
      cyc(0, 0, 0, 1, 2, 2, 0, 0);
      cyc(0, 0, 0, 1, 2, 2, 0, 0);
      #1;
      chk("err_underflow", {63'd0, err}, 64'd1);
      chk("alm_w2_zero", {63'd0, alm_empty}, 64'd1);
      saved_lock = warp_locked;
      cyc(0, 0, 0, 0, 0, 0, 1, 3);
      #1;
      chk("err_sticky", {63'd0, err}, 64'd1);
      chk("lock_unchanged", {60'd0, warp_locked}, {60'd0, saved_lock});

      // asynchronous reset while warp 2 is locked
      cyc(1, 2, 1, 0, 0, 2, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_lock", {60'd0, warp_locked}, 64'd0);
      chk("async_err", {63'd0, err}, 64'd0);
      chk("async_cycles", cycles, 64'd0);
      chk("async_aw", {60'd0, active_warps}, 64'd0);
      m_reset();
      issue_valid = 0; commit_valid = 0; unlock_warp = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;

`ifdef VX_CSR_TRACK_PERF_EN
      cyc(1, 1, 1, 0, 0, 1, 0, 0);
      repeat (5) cyc(1, 1, 0, 0, 0, 1, 0, 0);
      chk("stall_5", {32'd0, csr_stall_cycles}, 64'd5);
      cyc(0, 0, 0, 0, 0, 1, 1, 1);
`endif

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         int iw, cw, uw;
         bit cv, uv;
         iw = $urandom_range(0, 3);
         cw = $urandom_range(0, 3);
         uw = $urandom_range(0, 3);
         cv = (m_pend[cw] > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
         uv = m_lock[uw] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
         cyc(bit'($urandom_range(0, 1)), iw, ($urandom_range(0, 3) == 0), cv, cw,
             $urandom_range(0, 3), uv, uw);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
